readout_capture: RTL and testbench

READOUT_CAPTURE -- requirements
Module: readout_capture

---
 rtl/readout_pkg.sv | 25 ++
 rtl/iq_accumulator.sv | 39 +++
 rtl/readout_capture.sv | 131 +++++++++++++
 tb/tb_readout_capture.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and constants for the readout capture block.
package readout_pkg;

    localparam int DEF_TIME_W = 32;
    localparam int DEF_TLEN_W = 16;
    localparam int DEF_ACC_W  = 40;

    localparam int SAMPLE_W = 16;
    localparam int I_LSB    = 0;
    localparam int Q_LSB    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_TIME_W-1:0] t_start;
        logic [DEF_TLEN_W-1:0] t_len;
        logic [DEF_ACC_W-1:0]  threshold;
    } capture_descriptor_t;

endpackage

// File: rtl/iq_accumulator.sv
// Signed I/Q accumulator pair: clear, add on enabled beat, otherwise hold.
module iq_accumulator
    import readout_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] smp_i,
    input  logic [SAMPLE_W-1:0] smp_q,
    output logic [ACC_W-1:0]    nxt_i,
    output logic [ACC_W-1:0]    nxt_q
);

    logic [ACC_W-1:0] acc_i;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] ext_i;
    logic [ACC_W-1:0] ext_q;

    assign ext_i = {{(ACC_W-SAMPLE_W){smp_i[SAMPLE_W-1]}}, smp_i};
    assign ext_q = {{(ACC_W-SAMPLE_W){smp_q[SAMPLE_W-1]}}, smp_q};

    // nxt includes the current beat so the caller can latch a final sum
    assign nxt_i = en ? acc_i + ext_i : acc_i;
    assign nxt_q = en ? acc_q + ext_q : acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc_i <= '0;
            acc_q <= '0;
        end else begin
            acc_i <= nxt_i;
            acc_q <= nxt_q;
        end
    end

endmodule

// File: rtl/readout_capture.sv
// Time-windowed I/Q integration with threshold discrimination.
module readout_capture
    import readout_pkg::*;
#(
    parameter int TIME_W = DEF_TIME_W,
    parameter int TLEN_W = DEF_TLEN_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] counter,
    input  logic              cap_valid,
    output logic              cap_ready,
    input  logic [TIME_W-1:0] cap_t_start,
    input  logic [TLEN_W-1:0] cap_t_len,
    input  logic [ACC_W-1:0]  cap_threshold,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ACC_W-1:0]  res_i,
    output logic [ACC_W-1:0]  res_q,
    output logic              res_state,
    output logic              res_late,
    output logic              res_valid,
    input  logic              res_ready
);

    state_t              state;
    capture_descriptor_t desc;
    logic [TLEN_W-1:0]   cnt;
    logic                first_wait;
    logic                late_q;

    logic [TIME_W-1:0] t_start;
    logic [TLEN_W-1:0] t_len;
    logic [ACC_W-1:0]  thr;
    logic [TIME_W-1:0] diff;
    logic [TLEN_W-1:0] cnt_nxt;
    logic [ACC_W-1:0]  nxt_i;
    logic [ACC_W-1:0]  nxt_q;
    logic open, zero_len, cap_en, last, enter_done, late_now, clr;

    assign t_start = TIME_W'(desc.t_start);
    assign t_len   = TLEN_W'(desc.t_len);
    assign thr     = ACC_W'(desc.threshold);

    assign s_axis_tready = 1'b1;

    // wrap-safe: window is open once counter is at or past t_start
    assign diff     = counter - t_start;
    assign open     = (state == S_WAIT) && !diff[TIME_W-1];
    assign zero_len = (t_len == '0);
    assign late_now = first_wait && (counter != t_start);

    // the cycle the window opens is itself the first capture cycle
    assign cap_en = s_axis_tvalid &&
                    ((state == S_CAPTURE) || (open && !zero_len));
    assign cnt_nxt    = cnt + TLEN_W'(1);
    assign last       = cap_en && (cnt_nxt == t_len);
    assign enter_done = (open && zero_len) || last;
    assign clr        = cap_valid && cap_ready;

    iq_accumulator #(.ACC_W(ACC_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (cap_en),
        .smp_i (s_axis_tdata[I_LSB +: SAMPLE_W]),
        .smp_q (s_axis_tdata[Q_LSB +: SAMPLE_W]),
        .nxt_i (nxt_i),
        .nxt_q (nxt_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            desc       <= '0;
            cnt        <= '0;
            first_wait <= 1'b0;
            late_q     <= 1'b0;
            cap_ready  <= 1'b1;
            res_i      <= '0;
            res_q      <= '0;
            res_state  <= 1'b0;
            res_late   <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            if (enter_done) begin
                res_i     <= nxt_i;
                res_q     <= nxt_q;
                res_state <= ($signed(nxt_i) >= $signed(thr));
                res_late  <= (state == S_WAIT) ? late_now : late_q;
                res_valid <= 1'b1;
            end
            if (cap_en) cnt <= cnt_nxt;
            unique case (state)
                S_IDLE: begin
                    if (clr) begin
                        desc.t_start   <= DEF_TIME_W'(cap_t_start);
                        desc.t_len     <= DEF_TLEN_W'(cap_t_len);
                        desc.threshold <= DEF_ACC_W'(cap_threshold);
                        cnt            <= '0;
                        first_wait     <= 1'b1;
                        late_q         <= 1'b0;
                        cap_ready      <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    first_wait <= 1'b0;
                    if (open) begin
                        late_q <= late_now;
                        state  <= enter_done ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (last) state <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cap_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_readout_capture.sv
// Directed self-checking bench for readout_capture.
module tb_readout_capture;

    logic        clk;
    logic        rst_n;
    logic [31:0] counter;
    logic        ld;
    logic [31:0] ld_val;
    logic        cap_valid;
    logic        cap_ready;
    logic [31:0] cap_t_start;
    logic [15:0] cap_t_len;
    logic [39:0] cap_threshold;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [39:0] res_i;
    logic [39:0] res_q;
    logic        res_state;
    logic        res_late;
    logic        res_valid;
    logic        res_ready;

    int n_cmp = 0;
    int n_err = 0;

    readout_capture dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .counter       (counter),
        .cap_valid     (cap_valid),
        .cap_ready     (cap_ready),
        .cap_t_start   (cap_t_start),
        .cap_t_len     (cap_t_len),
        .cap_threshold (cap_threshold),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .res_i         (res_i),
        .res_q         (res_q),
        .res_state     (res_state),
        .res_late      (res_late),
        .res_valid     (res_valid),
        .res_ready     (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial counter = 32'd0;
    always @(posedge clk) counter <= ld ? ld_val : counter + 32'd1;

    task automatic load_counter(input logic [31:0] v);
        @(negedge clk);
        ld = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // handshake happens in the cycle the task starts in; returns at first WAIT cycle
    task automatic issue(input logic [31:0] ts, input logic [15:0] tl,
                         input logic [39:0] th);
        cap_valid = 1'b1;
        cap_t_start = ts;
        cap_t_len = tl;
        cap_threshold = th;
        @(negedge clk);
        cap_valid = 1'b0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_res_valid: got %b expected 0", res_valid);
        end
        n_cmp++;
        if (cap_ready !== 1'b1 || s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got cap=%b s=%b expected 1 1",
                     cap_ready, s_axis_tready);
        end
        n_cmp++;
        if ({res_i, res_q, res_state, res_late} !== 82'd0) begin
            n_err++;
            $display("FAIL reset_results: got i=%0h q=%0h st=%b late=%b expected 0",
                     res_i, res_q, res_state, res_late);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int sent = 0;
        bit seen = 0;
        bit ready_bad = 0;
        logic [31:0] c_done = 0;
        load_counter(32'd0);
        issue(32'd100, 16'd4, 40'd0);
        for (int c = 0; c < 300; c++) begin
            if (res_valid) begin
                seen = 1;
                c_done = counter;
                break;
            end
            if (cap_ready !== 1'b0) ready_bad = 1;
            if (counter >= 32'd100 && sent < 4) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata = {16'hFFFD, 16'h000A};
                sent++;
            end else begin
                s_axis_tvalid = 1'b0;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (!seen || c_done !== 32'd104) begin
            n_err++;
            $display("FAIL nominal_done_time: got seen=%b counter=%0d expected 104",
                     seen, c_done);
        end
        n_cmp++;
        if (ready_bad) begin
            n_err++;
            $display("FAIL nominal_cap_ready: got 1 outside IDLE expected 0");
        end
        n_cmp++;
        if (res_i !== 40'd40 || res_q !== 40'hFF_FFFF_FFF4) begin
            n_err++;
            $display("FAIL nominal_sums: got i=%0h q=%0h expected 28 fffffffff4",
                     res_i, res_q);
        end
        n_cmp++;
        if (res_state !== 1'b1 || res_late !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_flags: got st=%b late=%b expected 1 0",
                     res_state, res_late);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 20; k++) begin
            cap_valid = 1'b1;
            cap_t_start = counter;
            cap_t_len = 16'd1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata = {16'h1234, 16'h4321};
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b1 || res_i !== 40'd40 ||
                res_q !== 40'hFF_FFFF_FFF4 || res_state !== 1'b1 ||
                res_late !== 1'b0 || cap_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got v=%b i=%0h q=%0h st=%b cr=%b expected 1 28 fffffffff4 1 0",
                         k, res_valid, res_i, res_q, res_state, cap_ready);
            end
        end
        cap_valid = 1'b0;
        s_axis_tvalid = 1'b0;
        release_result();
        n_cmp++;
        if (res_valid !== 1'b0 || cap_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: got v=%b cr=%b expected 0 1",
                     res_valid, cap_ready);
        end
        n_cmp++;
        if (res_i !== 40'd40) begin
            n_err++;
            $display("FAIL hold_after_release: got %0h expected 28", res_i);
        end
    endtask

    task automatic test_gapped();
        logic [31:0] ts;
        logic [31:0] d;
        logic [4:0]  pat = 5'b11001;
        bit seen = 0;
        logic [31:0] c_done = 0;
        ts = counter + 32'd10;
        issue(ts, 16'd3, 40'd0);
        for (int c = 0; c < 100; c++) begin
            if (res_valid) begin
                seen = 1;
                c_done = counter;
                break;
            end
            d = counter - ts;
            if (d == 32'hFFFF_FFFE || d == 32'hFFFF_FFFF) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata = {16'd500, 16'd1000};
            end else if (d < 32'd5) begin
                s_axis_tvalid = pat[d[2:0]];
                s_axis_tdata = {16'd7, 16'hFFFB};
            end else begin
                s_axis_tvalid = 1'b0;
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (!seen || c_done !== ts + 32'd5) begin
            n_err++;
            $display("FAIL gapped_done_time: got seen=%b counter=%0d expected %0d",
                     seen, c_done, ts + 32'd5);
        end
        n_cmp++;
        if (res_i !== 40'hFF_FFFF_FFF1 || res_q !== 40'd21) begin
            n_err++;
            $display("FAIL gapped_sums: got i=%0h q=%0h expected fffffffff1 15",
                     res_i, res_q);
        end
        n_cmp++;
        if (res_state !== 1'b0 || res_late !== 1'b0) begin
            n_err++;
            $display("FAIL gapped_flags: got st=%b late=%b expected 0 0",
                     res_state, res_late);
        end
        release_result();
    endtask

    task automatic test_zero_len();
        for (int r = 0; r < 2; r++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = {16'd9, 16'd9};
            issue(counter + 32'd1, 16'd0, (r == 0) ? 40'd1 : 40'd0);
            n_cmp++;
            if (res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_wait[%0d]: got v=%b expected 0", r, res_valid);
            end
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            n_cmp++;
            if (res_valid !== 1'b1 || res_i !== 40'd0 || res_q !== 40'd0) begin
                n_err++;
                $display("FAIL zero_result[%0d]: got v=%b i=%0h q=%0h expected 1 0 0",
                         r, res_valid, res_i, res_q);
            end
            n_cmp++;
            if (res_state !== (r == 1) || res_late !== 1'b0) begin
                n_err++;
                $display("FAIL zero_flags[%0d]: got st=%b late=%b expected %0d 0",
                         r, res_state, res_late, r);
            end
            release_result();
        end
    endtask

    task automatic test_late_wrap();
        bit seen = 0;
        bit early = 0;
        logic [31:0] c_done = 0;
        load_counter(32'd5);
        issue(32'hFFFF_FFF0, 16'd2, 40'd100);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = {16'd1, 16'd60};
        repeat (2) @(negedge clk);
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b1 || counter !== 32'd8) begin
            n_err++;
            $display("FAIL late_done_time: got v=%b counter=%0d expected 1 8",
                     res_valid, counter);
        end
        n_cmp++;
        if (res_i !== 40'd120 || res_q !== 40'd2 ||
            res_state !== 1'b1 || res_late !== 1'b1) begin
            n_err++;
            $display("FAIL late_result: got i=%0d q=%0d st=%b late=%b expected 120 2 1 1",
                     res_i, res_q, res_state, res_late);
        end
        release_result();

        load_counter(32'hFFFF_FFFE);
        issue(32'h0000_0002, 16'd1, 40'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = {16'd2, 16'hFFFF};
        for (int c = 0; c < 20; c++) begin
            if (res_valid) begin
                seen = 1;
                c_done = counter;
                break;
            end
            if (counter == 32'd0 && cap_ready !== 1'b0) early = 1;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (!seen || c_done !== 32'd3 || early) begin
            n_err++;
            $display("FAIL wrap_done_time: got seen=%b counter=%0d cr_bad=%b expected 1 3 0",
                     seen, c_done, early);
        end
        n_cmp++;
        if (res_i !== 40'hFF_FFFF_FFFF || res_q !== 40'd2 ||
            res_state !== 1'b0 || res_late !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_result: got i=%0h q=%0h st=%b late=%b expected ffffffffff 2 0 0",
                     res_i, res_q, res_state, res_late);
        end
        release_result();
    endtask

    task automatic test_reset_abort();
        bit seen = 0;
        issue(counter + 32'd1, 16'd8, 40'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = {16'd4, 16'd11};
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (res_valid !== 1'b0 || cap_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_reset_out: got v=%b cr=%b expected 0 1",
                     res_valid, cap_ready);
        end
        n_cmp++;
        if (res_i !== 40'd0 || res_late !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset_res: got i=%0h late=%b expected 0 0",
                     res_i, res_late);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_no_result: got res_valid 1 expected 0");
        end
        s_axis_tdata = {16'd0, 16'd3};
        issue(counter + 32'd1, 16'd1, 40'd0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b1 || res_i !== 40'd3 || res_q !== 40'd0) begin
            n_err++;
            $display("FAIL abort_fresh: got v=%b i=%0h q=%0h expected 1 3 0",
                     res_valid, res_i, res_q);
        end
        release_result();
    endtask

    initial begin
        rst_n = 1'b0;
        ld = 1'b0;
        ld_val = 32'd0;
        cap_valid = 1'b0;
        cap_t_start = 32'd0;
        cap_t_len = 16'd0;
        cap_threshold = 40'd0;
        s_axis_tdata = 32'd0;
        s_axis_tvalid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_backpressure();
        test_gapped();
        test_zero_len();
        test_late_wrap();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
